// File: rtl/wshb_intercon_pkg.sv
// ============================================================================
// wshb_intercon_pkg : shared constants and helpers for wshb_intercon_rr
// Rev 1.0
// ============================================================================
`default_nettype none

package wshb_intercon_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Width of an owner index; a single-master build still needs one bit.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick, scanning from ptr+1 upwards
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
  import wshb_intercon_pkg::*;
#(
  parameter int NB_MASTERS = 4
) (
  input  logic [NB_MASTERS-1:0]            req,
  input  logic [owner_w(NB_MASTERS)-1:0]   ptr,
  output logic [NB_MASTERS-1:0]            gnt
);

  logic found;

  // Priority distance k=1 is the master just after ptr; ptr itself comes last.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= NB_MASTERS; k++) begin
      for (int i = 0; i < NB_MASTERS; i++) begin
        if (!found && req[i] && (i == ((int'(ptr) + k) % NB_MASTERS))) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wshb_intercon_rr.sv
// ============================================================================
// wshb_intercon_rr : N-master to 1-slave Wishbone interconnect, round robin
// Optional watchdog enabled by defining WSHB_INTERCON_TIMEOUT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module wshb_intercon_rr
  import wshb_intercon_pkg::*;
#(
  parameter int NB_MASTERS = 4,
  parameter int ADR_W      = 32,
  parameter int DAT_W      = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NB_MASTERS-1:0]               m_cyc,
  input  logic [NB_MASTERS-1:0]               m_stb,
  input  logic [NB_MASTERS-1:0]               m_we,
  input  logic [NB_MASTERS-1:0][ADR_W-1:0]    m_adr,
  input  logic [NB_MASTERS-1:0][DAT_W-1:0]    m_dat_ms,
  input  logic [NB_MASTERS-1:0][DAT_W/8-1:0]  m_sel,
  input  logic [NB_MASTERS-1:0][2:0]          m_cti,
  input  logic [NB_MASTERS-1:0][1:0]          m_bte,
  output logic [NB_MASTERS-1:0]               m_ack,
  output logic [NB_MASTERS-1:0]               m_err,
  output logic [NB_MASTERS-1:0]               m_rty,
  output logic [DAT_W-1:0]                    m_dat_sm,
  output logic                                s_cyc,
  output logic                                s_stb,
  output logic                                s_we,
  output logic [ADR_W-1:0]                    s_adr,
  output logic [DAT_W-1:0]                    s_dat_ms,
  output logic [DAT_W/8-1:0]                  s_sel,
  output logic [2:0]                          s_cti,
  output logic [1:0]                          s_bte,
  input  logic                                s_ack,
  input  logic                                s_err,
  input  logic                                s_rty,
  input  logic [DAT_W-1:0]                    s_dat_sm,
  output logic [NB_MASTERS-1:0]               gnt,
  output logic                                timeout_o
);

  localparam int OW = owner_w(NB_MASTERS);

  logic                  owner_vld;
  logic [OW-1:0]         owner;
  logic [OW-1:0]         last;
  logic [OW-1:0]         nxt_idx;
  logic [NB_MASTERS-1:0] arb_gnt;
  logic                  own_cyc;
  logic                  rearb;
  logic                  tmo;

  // The owner keeps the bus for as long as it holds cyc; re-arbitrate otherwise.
  assign own_cyc = owner_vld & m_cyc[owner];
  assign rearb   = ~own_cyc;

  rr_arbiter #(
    .NB_MASTERS (NB_MASTERS)
  ) u_arb (
    .req (m_cyc),
    .ptr (last),
    .gnt (arb_gnt)
  );

  always_comb begin
    nxt_idx = '0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      if (arb_gnt[i]) nxt_idx = OW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_vld <= 1'b0;
      owner     <= '0;
      last      <= OW'(NB_MASTERS - 1);
    end else if (rearb) begin
      if (|arb_gnt) begin
        owner_vld <= 1'b1;
        owner     <= nxt_idx;
        last      <= nxt_idx;
      end else begin
        owner_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (owner_vld) gnt[owner] = 1'b1;
  end

  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    s_cti    = '0;
    s_bte    = '0;
    m_ack    = '0;
    m_err    = '0;
    m_rty    = '0;
    if (owner_vld) begin
      s_cyc        = m_cyc[owner];
      s_stb        = m_stb[owner] & ~tmo;
      s_we         = m_we[owner];
      s_adr        = m_adr[owner];
      s_dat_ms     = m_dat_ms[owner];
      s_sel        = m_sel[owner];
      s_cti        = m_cti[owner];
      s_bte        = m_bte[owner];
      m_ack[owner] = s_ack;
      m_err[owner] = s_err | tmo;
      m_rty[owner] = s_rty;
    end
  end

  assign m_dat_sm = s_dat_sm;

`ifdef WSHB_INTERCON_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt;
  logic          stall;

  assign stall = own_cyc & m_stb[owner] & ~(s_ack | s_err | s_rty);
  assign tmo   = owner_vld & (wd_cnt == CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst_n || rearb || !stall || tmo) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  // Watchdog absent: keep the limit referenced so the parameter is not dangling.
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign tmo            = 1'b0;
`endif

  assign timeout_o = tmo;

endmodule

`default_nettype wire

// File: tb/tb_wshb_intercon_rr.sv
// ============================================================================
// tb_wshb_intercon_rr : directed self-checking bench for wshb_intercon_rr
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wshb_intercon_rr;

  localparam int N = 4;
  localparam logic [2:0] INCR = 3'b010;
  localparam logic [2:0] EOB  = 3'b111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [N-1:0]        m_cyc, m_stb, m_we;
  logic [N-1:0][31:0]  m_adr, m_dat_ms;
  logic [N-1:0][3:0]   m_sel;
  logic [N-1:0][2:0]   m_cti;
  logic [N-1:0][1:0]   m_bte;
  logic [N-1:0]        m_ack, m_err, m_rty;
  logic [31:0]         m_dat_sm;
  logic                s_cyc, s_stb, s_we;
  logic [31:0]         s_adr, s_dat_ms;
  logic [3:0]          s_sel;
  logic [2:0]          s_cti;
  logic [1:0]          s_bte;
  logic                s_ack, s_err, s_rty;
  logic [31:0]         s_dat_sm;
  logic [N-1:0]        gnt;
  logic                timeout_o;

  int checks = 0;
  int errors = 0;

  logic [3:0] order [5];
  logic [3:0] cur;
  int         pulses;

  always #5 clk = ~clk;

  wshb_intercon_rr #(
    .NB_MASTERS (N),
    .ADR_W      (32),
    .DAT_W      (32),
    .TIMEOUT    (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m_cyc     (m_cyc),
    .m_stb     (m_stb),
    .m_we      (m_we),
    .m_adr     (m_adr),
    .m_dat_ms  (m_dat_ms),
    .m_sel     (m_sel),
    .m_cti     (m_cti),
    .m_bte     (m_bte),
    .m_ack     (m_ack),
    .m_err     (m_err),
    .m_rty     (m_rty),
    .m_dat_sm  (m_dat_sm),
    .s_cyc     (s_cyc),
    .s_stb     (s_stb),
    .s_we      (s_we),
    .s_adr     (s_adr),
    .s_dat_ms  (s_dat_ms),
    .s_sel     (s_sel),
    .s_cti     (s_cti),
    .s_bte     (s_bte),
    .s_ack     (s_ack),
    .s_err     (s_err),
    .s_rty     (s_rty),
    .s_dat_sm  (s_dat_sm),
    .gnt       (gnt),
    .timeout_o (timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    order[0] = 4'b0001;
    order[1] = 4'b0010;
    order[2] = 4'b0100;
    order[3] = 4'b1000;
    order[4] = 4'b0001;

    m_cyc = 4'b1111; m_stb = 4'b1111; m_we = '0;
    for (int i = 0; i < N; i++) begin
      m_adr[i]    = 32'h1000_0000 + 32'(i * 16);
      m_dat_ms[i] = 32'hA0A0_0000 + 32'(i);
      m_sel[i]    = 4'hF;
      m_cti[i]    = 3'b000;
      m_bte[i]    = 2'b00;
    end
    s_ack = 1'b1; s_err = 1'b0; s_rty = 1'b0; s_dat_sm = '0;

    // Reset held with everyone requesting and a stray slave ack.
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_gnt",   32'(gnt),       32'h0);
    chk("rst_s_cyc", 32'(s_cyc),     32'h0);
    chk("rst_s_stb", 32'(s_stb),     32'h0);
    chk("rst_tmo",   32'(timeout_o), 32'h0);
    chk("rst_m_ack", 32'(m_ack),     32'h0);
    m_cyc = '0; m_stb = '0; s_ack = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single request from master 2: one cycle grant latency.
    m_cyc = 4'b0100; m_stb = 4'b0100; m_we = 4'b0100;
    #1;
    chk("lat_gnt_early", 32'(gnt),   32'h0);
    chk("lat_scyc_early", 32'(s_cyc), 32'h0);
    tick();
    chk("m2_gnt",   32'(gnt),   32'h4);
    chk("m2_s_cyc", 32'(s_cyc), 32'h1);
    chk("m2_s_adr", s_adr,      32'h1000_0020);
    chk("m2_s_we",  32'(s_we),  32'h1);
    chk("m2_s_dat", s_dat_ms,   32'hA0A0_0002);
    s_ack = 1'b1; #1;
    chk("m2_ack", 32'(m_ack), 32'h4);
    tick();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0;
    tick();
    chk("idle_gnt",   32'(gnt),  32'h0);
    chk("idle_s_adr", s_adr,     32'h0);
    chk("idle_s_we",  32'(s_we), 32'h0);
    tick(); tick();

    // Pointer survives idle gap: last owner 2, so 3 beats 0.
    m_cyc = 4'b1001; m_stb = 4'b1001;
    tick();
    chk("fair_gnt3", 32'(gnt), 32'h8);
    m_cyc = 4'b0001; m_stb = 4'b0001;
    tick();
    chk("handover_gnt0", 32'(gnt), 32'h1);
    m_cyc = '0; m_stb = '0;
    tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;

    // Four-way contention, each owner leaves after one ack.
    m_cyc = 4'b1111; m_stb = 4'b1111;
    tick();
    chk("rr_first", 32'(gnt), 32'(order[0]));
    for (int k = 0; k < 4; k++) begin
      cur = order[k];
      s_ack = 1'b1; #1;
      chk("rr_ack", 32'(m_ack), 32'(cur));
      tick();
      s_ack = 1'b0;
      m_cyc = m_cyc & ~cur; m_stb = m_stb & ~cur;
      tick();
      chk("rr_next", 32'(gnt), 32'(order[k+1]));
      m_cyc = m_cyc | cur; m_stb = m_stb | cur;
    end
    m_cyc = '0; m_stb = '0;
    tick();
    chk("rr_idle", 32'(gnt), 32'h0);

    // Master 1 8-beat burst must not be preempted by master 3.
    m_cyc = 4'b1010; m_stb = 4'b1010; m_cti[1] = INCR;
    tick();
    chk("burst_gnt", 32'(gnt), 32'h2);
    for (int b = 0; b < 8; b++) begin
      if (b == 7) m_cti[1] = EOB;
      s_ack = 1'b1; #1;
      chk("burst_hold", 32'(gnt), 32'h2);
      if (b == 7) chk("burst_eob", 32'(s_cti), 32'(EOB));
      tick();
    end
    s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_cti[1] = 3'b000;
    #1;
    chk("burst_drop_hold", 32'(gnt), 32'h2);
    tick();
    chk("burst_next_gnt", 32'(gnt), 32'h8);
    chk("burst_next_adr", s_adr,    32'h1000_0030);

    // Read by master 0: terminations go to owner only, data broadcast.
    m_cyc = 4'b0001; m_stb = 4'b0001;
    tick();
    chk("rd_gnt", 32'(gnt), 32'h1);
    s_ack = 1'b1; s_dat_sm = 32'hDEADBEEF; #1;
    chk("rd_ack", 32'(m_ack), 32'h1);
    chk("rd_dat", m_dat_sm,   32'hDEADBEEF);
    s_ack = 1'b0; s_err = 1'b1; #1;
    chk("rd_err", 32'(m_err), 32'h1);
    s_err = 1'b0; s_rty = 1'b1; #1;
    chk("rd_rty", 32'(m_rty), 32'h1);
    s_rty = 1'b0;
    m_cyc = '0; m_stb = '0;
    tick();

    // Watchdog: slave never answers.
    m_cyc = 4'b0001; m_stb = 4'b0001;
    tick();
    chk("wd_gnt",   32'(gnt),   32'h1);
    chk("wd_s_stb", 32'(s_stb), 32'h1);
    pulses = 0;
    for (int k = 1; k < 16; k++) begin
      tick();
      if (timeout_o || m_err[0]) pulses++;
    end
    chk("wd_early", 32'(pulses), 32'h0);
    tick();
`ifdef WSHB_INTERCON_TIMEOUT_EN
    chk("wd_pulse", 32'(timeout_o), 32'h1);
    chk("wd_err",   32'(m_err),     32'h1);
    chk("wd_stb",   32'(s_stb),     32'h0);
    tick();
    chk("wd_one_cycle", 32'(timeout_o), 32'h0);
    chk("wd_stb_back",  32'(s_stb),     32'h1);
`else
    chk("wd_none_tmo", 32'(timeout_o), 32'h0);
    chk("wd_none_err", 32'(m_err),     32'h0);
    chk("wd_none_stb", 32'(s_stb),     32'h1);
`endif

    // Reset in the middle of a burst, with the slave acking.
    m_cyc = 4'b1111; m_stb = 4'b1111; m_cti[0] = INCR;
    s_ack = 1'b1; #1;
    chk("mid_ack", 32'(m_ack), 32'h1);
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_gnt",   32'(gnt),   32'h0);
    chk("mid_rst_s_cyc", 32'(s_cyc), 32'h0);
    chk("mid_rst_m_ack", 32'(m_ack), 32'h0);
    rst_n = 1'b1; s_ack = 1'b0;
    tick();
    chk("post_rst_gnt", 32'(gnt),   32'h1);
    chk("post_rst_cti", 32'(s_cti), 32'(INCR));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
